// File: rtl/vga_sync_if.sv
// VGA timing bundle between the pixel-enable divider, the sync generator and the pixel-colour logic.
// frame_count is only live when vga_sync_gen is built with VGA_FRAME_COUNT_EN.
interface vga_sync_if;
   logic       pix_en;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_tick;
   logic [7:0] frame_count;

   modport master (
      input  pix_en,
      output hsync, vsync, video_on, pixel_x, pixel_y, frame_tick, frame_count
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, video_on, pixel_x, pixel_y, frame_tick, frame_count
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 sync generator, clocked at 100 MHz and advanced by a pixel-rate enable.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit frames-since-reset counter.
module vga_sync_gen #(
   parameter int H_DISP = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_DISP = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       reset,
   vga_sync_if.master vga
);
   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISP);
   localparam logic [9:0] V_VIS    = 10'(V_DISP);
   localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

   logic [9:0] h_cnt, v_cnt;
   logic [9:0] h_next, v_next;
   logic       line_end, frame_end;
   logic       hsync_q, vsync_q, video_q, tick_q;

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);

   // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      h_next = h_cnt + 10'd1;
      v_next = v_cnt;
      if (line_end) begin
         h_next = '0;
         v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end
   end

   // Flags are decoded from the next-state counters so they line up with the coordinates.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt   <= H_LAST;
         v_cnt   <= V_LAST;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         video_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= vga.pix_en && frame_end;
         if (vga.pix_en) begin
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync_q <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync_q <= !((v_next >= VS_START) && (v_next < VS_END));
            video_q <= (h_next < H_VIS) && (v_next < V_VIS);
         end
      end
   end

   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.video_on   = video_q;
   assign vga.pixel_x    = h_cnt;
   assign vga.pixel_y    = v_cnt;
   assign vga.frame_tick = tick_q;

`ifdef VGA_FRAME_COUNT_EN
   // Advances on the wrap edge itself, so the first frame already reads 1 alongside its tick.
   logic [7:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt <= '0;
      end else if (vga.pix_en && frame_end) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign vga.frame_count = frame_cnt;
`else
   assign vga.frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: a full-size instance plus a shrunken-timing instance for whole frames.
// Expected values come from an arithmetic position model driven by the count of enabled edges.
module tb_vga_sync_gen;
   localparam int BH_D = 640, BH_F = 16, BH_S = 96, BH_B = 48;
   localparam int BV_D = 480, BV_F = 10, BV_S = 2,  BV_B = 33;
   localparam int SH_D = 8,   SH_F = 2,  SH_S = 3,  SH_B = 2;
   localparam int SV_D = 6,   SV_F = 2,  SV_S = 1,  SV_B = 2;

   logic clk;
   logic reset;

   vga_sync_if vga_b ();
   vga_sync_if vga_s ();

   vga_sync_gen dut_big (
      .clk   (clk),
      .reset (reset),
      .vga   (vga_b.master)
   );

   vga_sync_gen #(
      .H_DISP (SH_D), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
      .V_DISP (SV_D), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
   ) dut_small (
      .clk   (clk),
      .reset (reset),
      .vga   (vga_s.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Position after n enabled edges since reset: edge k (1-based) shows linear position k-1.
   function automatic logic [31:0] model(input int n, input bit tick,
                                         input int hd, input int hf, input int hs, input int hb,
                                         input int vd, input int vf, input int vs, input int vb);
      int ht, vt, f, x, y, frames;
      bit hs_n, vs_n, von;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      f  = ht * vt;
      if (n == 0) begin
         x = ht - 1;
         y = vt - 1;
         frames = 0;
      end else begin
         x = ((n - 1) % f) % ht;
         y = ((n - 1) % f) / ht;
         frames = (n - 1) / f + 1;
      end
`ifndef VGA_FRAME_COUNT_EN
      frames = 0;
`endif
      hs_n = !((x >= hd + hf) && (x < hd + hf + hs));
      vs_n = !((y >= vd + vf) && (y < vd + vf + vs));
      von  = (x < hd) && (y < vd);
      return {hs_n, vs_n, von, tick, 10'(x), 10'(y), 8'(frames % 256)};
   endfunction

   int n_b = 0, n_s = 0;
   bit tick_b = 0, tick_s = 0;

   function automatic logic [31:0] observed_b();
      return {vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.frame_tick,
              vga_b.pixel_x, vga_b.pixel_y, vga_b.frame_count};
   endfunction

   function automatic logic [31:0] observed_s();
      return {vga_s.hsync, vga_s.vsync, vga_s.video_on, vga_s.frame_tick,
              vga_s.pixel_x, vga_s.pixel_y, vga_s.frame_count};
   endfunction

   // One clk: drive inputs, take the edge, advance the model, compare both instances.
   task automatic step(input bit rst_n, input bit pe_b, input bit pe_s);
      reset        = rst_n;
      vga_b.pix_en = pe_b;
      vga_s.pix_en = pe_s;
      @(posedge clk);
      #1;
      tick_b = 1'b0;
      tick_s = 1'b0;
      if (!rst_n) begin
         n_b = 0;
         n_s = 0;
      end else begin
         if (pe_b) begin
            n_b++;
            tick_b = ((n_b - 1) % ((BH_D + BH_F + BH_S + BH_B) * (BV_D + BV_F + BV_S + BV_B)) == 0);
         end
         if (pe_s) begin
            n_s++;
            tick_s = ((n_s - 1) % ((SH_D + SH_F + SH_S + SH_B) * (SV_D + SV_F + SV_S + SV_B)) == 0);
         end
      end
      check("big", observed_b(), model(n_b, tick_b, BH_D, BH_F, BH_S, BH_B, BV_D, BV_F, BV_S, BV_B));
      check("small", observed_s(), model(n_s, tick_s, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B));
   endtask

   initial begin
      reset        = 1'b0;
      vga_b.pix_en = 1'b0;
      vga_s.pix_en = 1'b0;

      // Reset dominates a toggling enable.
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'($urandom));
      check("rst_x", 32'(vga_b.pixel_x), 32'd799);
      check("rst_y", 32'(vga_b.pixel_y), 32'd524);
      check("rst_sync", 32'({vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.frame_tick}), 32'b1100);

      // Released: full-size runs at 25 MHz cadence, small instance gets random enables.
      for (int i = 0; i < 7000; i++) begin
         step(1'b1, (i % 4) == 0, 1'($urandom_range(0, 1)));
         if (i == 0) begin
            check("first_xy", 32'({vga_b.pixel_x, vga_b.pixel_y}), 32'd0);
            check("first_tick", 32'(vga_b.frame_tick), 32'd1);
            check("first_von", 32'(vga_b.video_on), 32'd1);
         end
         if (i == 1) check("tick_width", 32'(vga_b.frame_tick), 32'd0);
         if (i == 639 * 4) check("von_639", 32'(vga_b.video_on), 32'd1);
         if (i == 640 * 4) check("von_640", 32'(vga_b.video_on), 32'd0);
         if (i == 655 * 4) check("hs_655", 32'(vga_b.hsync), 32'd1);
         if (i == 656 * 4) check("hs_656", 32'(vga_b.hsync), 32'd0);
         if (i == 751 * 4) check("hs_751", 32'(vga_b.hsync), 32'd0);
         if (i == 752 * 4) check("hs_752", 32'(vga_b.hsync), 32'd1);
         if (i == 3200) check("line1_xy", 32'({vga_b.pixel_x, vga_b.pixel_y}), {22'd0, 10'd1});
      end

      // Mid-frame reset returns straight to the pre-frame state.
      step(1'b0, 1'b1, 1'b1);
      check("midrst_xy", 32'({vga_b.pixel_x, vga_b.pixel_y}), {12'd0, 10'd799, 10'd524});
      step(1'b0, 1'($urandom), 1'($urandom));
      for (int i = 0; i < 200; i++) step(1'b1, 1'($urandom), 1'($urandom));

      // Continuous enable: the small instance runs past 257 frames, so frame_count wraps.
      for (int i = 0; i < 43000; i++) step(1'b1, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the pixel-rate enable derived from the 100 MHz board clock.
- Generates VGA 640x480@60 timing: hsync, vsync, visible-area flag, current pixel coordinates, start-of-frame pulse.
- Sits between the clock-enable divider and the piece-animation/pixel-colour logic.
- Runs entirely in the 100 MHz domain. Counters advance only on enabled cycles; no derived clock is used as a clock.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- Derived: H_TOTAL = 800, V_TOTAL = 525. Counter width is 10 bits; parameters must keep totals ≤ 1024.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-low
- pix_en  in  1  pixel-rate enable, one clk cycle wide (every 4th clk at 25 MHz)
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high while the current position is in the visible area
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- frame_tick  out  1  one-clk pulse at the start of each frame
- frame_count  out  8  frames since reset (optional feature only)

Behaviour:
- All outputs are registered. No combinational path from input to output.
- Reset (reset=0 at a clk edge):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so pixel_x = 799 and pixel_y = 524.
  - hsync = 1, vsync = 1, video_on = 0, frame_tick = 0, frame_count = 0.
  - Reset has priority over pix_en. Reset mid-frame immediately returns to this state.
- The first pix_en after reset release wraps the counters to (0,0) and fires frame_tick. Pixel (0,0) is therefore the first displayed pixel.
- On a clk edge with pix_en=1:
  - If h_cnt == H_TOTAL-1: h_cnt becomes 0. Then, if v_cnt == V_TOTAL-1, v_cnt becomes 0; otherwise v_cnt increments.
  - Otherwise h_cnt increments.
- On a clk edge with pix_en=0: all counters and outputs hold, except frame_tick, which is forced to 0.
- hsync, vsync and video_on are decoded from the next-state counters, so they are cycle-aligned with the pixel_x/pixel_y values presented alongside them. Zero latency between coordinate and sync flags.
- Decodes:
  - hsync = 0 iff H_DISP+H_FP ≤ h < H_DISP+H_FP+H_SYNC, i.e. h in 656..751.
  - vsync = 0 iff V_DISP+V_FP ≤ v < V_DISP+V_FP+V_SYNC, i.e. v in 490..491.
  - video_on = 1 iff h < H_DISP and v < V_DISP.
- frame_tick = 1 for exactly one clk, on the edge where the counters wrap (799,524) → (0,0).
- pix_en held high continuously is legal: counters advance every clk (simulation speed-up).
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No out-of-range state is reachable.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - frame_count increments (mod 256) on every clk where frame_tick is asserted, including the first wrap after reset (first frame reads 1).
  - 255 wraps to 0.
  - Reset clears it to 0.
  - Used by the animation logic for piece-motion timing.
- Undefined: frame_count is tied to 8'd0 and no counter register is synthesised.

Test Plan:
- Reset held 5 clks with pix_en toggling → pixel_x=799, pixel_y=524, hsync=1, vsync=1, video_on=0, frame_tick=0 throughout.
- Release reset, pix_en every 4th clk → first enabled edge gives (0,0), video_on=1, frame_tick=1 for 1 clk. Next line start (0,1) occurs 3200 clks later.
- Step line 0 → hsync low exactly for pixel_x 656..751 (96 enables = 384 clks). video_on drops at pixel_x=640.
- Run a full frame with pix_en continuous → vsync low for pixel_y 490..491 (1600 clks). frame_tick period = 420000 clks. video_on=0 for all y ≥ 480.
- Assert reset at (300,200) → next clk shows (799,524) with hsync/vsync=1. First pix_en after release restarts at (0,0) with frame_tick.
- With VGA_FRAME_COUNT_EN and pix_en continuous, run 257 frames → frame_count reads 1, 2, …, 255, 0, 1. Without the macro it stays 0.
